clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Programmable integer clock divider for i_ref_clk with a runtime ratio and duty.
//  Generates a registered, glitch-free o_div_clk and a one-cycle o_tick at the start of each divided period.
//  Ratio/duty changes and enable drops take effect only at period boundaries, so no runt pulses.
//  Feeds peripheral clocking (e.g. UART TX/RX oversample) from the system reference clock.
// PARAMETERS
//  RATIO_WD  8  width of ratio/duty inputs and internal counter; max ratio 2**RATIO_WD-1
// PORTS
//  i_ref_clk     in   1         reference clock; all logic on posedge only
//  i_rst         in   1         asynchronous, active-high reset
//  i_clk_en      in   1         divider enable (level)
//  i_div_ratio   in   RATIO_WD  division ratio N; values <2 clamped to 2
//  i_duty        in   RATIO_WD  high-phase length H in ref cycles; 0 = default floor(N/2)
//  o_div_clk     out  1         divided clock, registered
//  o_tick        out  1         1-cycle pulse, first ref cycle of each divided period
//  o_busy        out  1         1 when state != IDLE
//  o_cfg_clamped out  1         1 if currently latched N or H was clamped
// BEHAVIOUR
//  Reset: async; state=IDLE, cnt=0, N_cur=2, H_cur=1; all outputs 0 immediately and while i_rst=1.
//  Config latch: N_cur/H_cur load only on period start (IDLE->RUN or wrap); mid-period input changes ignored.
//   N_cur = (i_div_ratio<2) ? 2 : i_div_ratio.
//   H_cur = (i_duty==0) ? N_cur>>1 : min(max(i_duty,1), N_cur-1).
//   o_cfg_clamped <= (ratio clamped) | (nonzero duty clamped); updates at the same edge.
//  Counter cnt: RATIO_WD bits, counts 0..N_cur-1; wrap compares against N_cur-1; no overflow.
//  Outputs are registered from next-state values: o_div_clk <= (next_state!=IDLE) && (cnt_next < H_cur_next).
//  Output timing:
//   o_div_clk high for H_cur cycles, then low for N_cur-H_cur cycles.
//   o_tick=1 exactly in the cycle where cnt==0 (period start).
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE: if i_clk_en=1 at edge -> RUN, cnt=0, latch cfg, o_div_clk=1, o_tick=1 (1-edge latency). Else outputs 0.
//   RUN: cnt++ each edge.
//    At boundary (cnt==N_cur-1): en=1 -> cnt=0, relatch cfg, tick; en=0 -> IDLE, o_div_clk=0.
//    Not at boundary: en=0 -> DRAIN, cnt++.
//   DRAIN: period continues unchanged, o_busy=1, o_tick only at period start.
//    en=1 before boundary -> RUN, no output disturbance.
//    At boundary: en=1 -> RUN with wrap/relatch/tick; en=0 -> IDLE, outputs 0.
//  Simultaneous boundary + cfg change: new cfg applies to the period starting at that edge.
//  o_div_clk never changes except per the counter compare -> no pulse shorter than min(H_cur, N_cur-H_cur) ref cycles.
//  Reset mid-operation: output drops asynchronously; after release, IDLE; restart waits for en sampled at a posedge.
// TESTING
//  N=4, duty=0, en=1 at edge 0 -> o_div_clk 1,1,0,0 repeating, o_tick at cnt 0, periods of 4.
//  N=5, duty=0 -> high 2 / low 3; N=5, duty=4 -> high 4 / low 1; tick every 5 cycles.
//  N 4->6 at cnt=1 -> current period finishes as 4 cycles, next periods are 6 (high 3), no runt.
//  en dropped at cnt=1 (N=8) -> o_busy stays 1, o_div_clk finishes 4h/4l, then 0 and busy=0 after 8th cycle.
//    en re-raised at cnt=5 -> seamless continuation, no extra tick.
//  N=1, duty=0 -> N_cur=2, 1h/1l, o_cfg_clamped=1.
//    N=4, duty=9 -> H=3, o_cfg_clamped=1. N=4, duty=2 -> o_cfg_clamped=0.
//  i_rst pulse mid high phase (N=6) -> outputs 0 immediately.
//    After release with en=1, first posedge restarts at cnt=0 with tick.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: runtime ratio/duty, registered glitch-free output,
// one-cycle tick per divided period; config and enable changes act only at period boundaries.
module clk_div_prog #(
    parameter int RATIO_WD = 8
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    input  logic [RATIO_WD-1:0] i_duty,
    output logic                o_div_clk,
    output logic                o_tick,
    output logic                o_busy,
    output logic                o_cfg_clamped
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic [RATIO_WD-1:0] n_q, n_d;
    logic [RATIO_WD-1:0] h_q, h_d;
    logic                clamped_q, clamped_d;
    logic                div_q, div_d;
    logic                tick_q, tick_d;

    logic [RATIO_WD-1:0] n_new, h_new;
    logic                clamped_new;
    logic                boundary;
    logic                latch;

    // Sanitised configuration, only consumed at a period start.
    always_comb begin
        n_new = (i_div_ratio < RATIO_WD'(2)) ? RATIO_WD'(2) : i_div_ratio;
        if (i_duty == '0) begin
            h_new = n_new >> 1;
        end else if (i_duty > n_new - RATIO_WD'(1)) begin
            h_new = n_new - RATIO_WD'(1);
        end else begin
            h_new = i_duty;
        end
        clamped_new = (i_div_ratio < RATIO_WD'(2)) |
                      ((i_duty != '0) & (i_duty > n_new - RATIO_WD'(1)));
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= RATIO_WD'(2);
            h_q       <= RATIO_WD'(1);
            clamped_q <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            h_q       <= h_d;
            clamped_q <= clamped_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch    = 1'b0;
        boundary = (cnt_q == n_q - RATIO_WD'(1));
        case (state_q)
            IDLE: begin
                if (i_clk_en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                // Enable only matters at the boundary; mid-period it just selects RUN vs DRAIN.
                if (boundary) begin
                    cnt_d = '0;
                    if (i_clk_en) begin
                        state_d = RUN;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + RATIO_WD'(1);
                    state_d = i_clk_en ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        n_d       = latch ? n_new       : n_q;
        h_d       = latch ? h_new       : h_q;
        clamped_d = latch ? clamped_new : clamped_q;
    end

    always_comb begin
        div_d  = (state_d != IDLE) && (cnt_d < h_d);
        tick_d = (state_d != IDLE) && (cnt_d == '0);
    end

    assign o_div_clk     = div_q;
    assign o_tick        = tick_q;
    assign o_busy        = (state_q != IDLE);
    assign o_cfg_clamped = clamped_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic against a period-level model.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [7:0] div_ratio;
    logic [7:0] duty;
    logic       div_clk, tick, busy, cfg_clamped;

    int checks = 0;
    int errors = 0;

    // Model: a period is either active or not; enable and config are looked at only when a period starts.
    bit m_active;
    int m_pos;
    int m_n;
    int m_h;
    bit m_clamp;

    clk_div_prog #(.RATIO_WD(8)) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_clk_en     (clk_en),
        .i_div_ratio  (div_ratio),
        .i_duty       (duty),
        .o_div_clk    (div_clk),
        .o_tick       (tick),
        .o_busy       (busy),
        .o_cfg_clamped(cfg_clamped)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_n      = 2;
        m_h      = 1;
        m_clamp  = 1'b0;
    endtask

    task automatic model_start(input int r, input int d);
        m_pos   = 0;
        m_n     = (r < 2) ? 2 : r;
        if (d == 0) m_h = m_n / 2;
        else        m_h = (d > m_n - 1) ? m_n - 1 : d;
        m_clamp = (r < 2) || (d != 0 && d > m_n - 1);
    endtask

    task automatic model_edge(input bit en, input int r, input int d);
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                model_start(r, d);
            end
        end else if (m_pos == m_n - 1) begin
            if (en) model_start(r, d);
            else begin
                m_active = 1'b0;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".div_clk"}, div_clk, m_active && (m_pos < m_h));
        chk({tag, ".tick"},    tick,    m_active && (m_pos == 0));
        chk({tag, ".busy"},    busy,    m_active);
        chk({tag, ".clamped"}, cfg_clamped, m_clamp);
    endtask

    // Drive inputs, take one rising edge, then check away from the edge.
    task automatic step(input string tag, input bit en, input int r, input int d);
        clk_en    = en;
        div_ratio = r[7:0];
        duty      = d[7:0];
        @(posedge clk);
        model_edge(en, r, d);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        compare({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        div_ratio = 8'd4;
        duty      = 8'd0;
        model_reset();
        #1;
        compare("reset");
        @(negedge clk);
        compare("reset_hold");
        rst = 1'b0;

        step("idle", 0, 4, 0);
        for (int i = 0; i < 12; i++) step("n4", 1, 4, 0);
        for (int i = 0; i < 15; i++) step("n5", 1, 5, 0);
        for (int i = 0; i < 15; i++) step("n5d4", 1, 5, 4);

        // Ratio change in the middle of a period.
        while (!(m_active && m_pos == 3)) step("n4_sync", 1, 4, 0);
        step("n4_sync", 1, 4, 0);
        step("n4_to6", 1, 6, 0);
        for (int i = 0; i < 14; i++) step("n6", 1, 6, 0);

        // Enable drop and drain, then drop-and-reraise.
        while (!(m_active && m_pos == 5)) step("n8_sync", 1, 8, 0);
        for (int i = 0; i < 3; i++) step("n8", 1, 8, 0);
        for (int i = 0; i < 10; i++) step("drain", 0, 8, 0);
        for (int i = 0; i < 2; i++) step("n8b", 1, 8, 0);
        for (int i = 0; i < 4; i++) step("drain2", 0, 8, 0);
        for (int i = 0; i < 12; i++) step("reraise", 1, 8, 0);

        // Clamping cases.
        for (int i = 0; i < 10; i++) step("n1", 1, 1, 0);
        for (int i = 0; i < 10; i++) step("n4d9", 1, 4, 9);
        for (int i = 0; i < 10; i++) step("n4d2", 1, 4, 2);
        for (int i = 0; i < 6; i++) step("n255", 1, 255, 255);

        // Reset during the high phase of an N=6 period.
        do_reset("rst_a");
        step("n6r", 1, 6, 0);
        step("n6r", 1, 6, 0);
        do_reset("rst_mid");
        for (int i = 0; i < 8; i++) step("restart", 1, 6, 0);

        for (int i = 0; i < 1500; i++) begin
            bit en;
            int r, d;
            en = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 10);
            d  = $urandom_range(0, 12);
            step("rand", en, r, d);
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
